// File: rtl/nios_mtl_pkg.sv
// nios_mtl_pkg: shared FSM states and sysid control-slave word addresses
package nios_mtl_pkg;
    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ_ID,
        S_WAIT_ID,
        S_REQ_TS,
        S_WAIT_TS,
        S_FINISH
    } state_t;
    localparam logic ADDR_ID        = 1'b0;
    localparam logic ADDR_TIMESTAMP = 1'b1;
endpackage

// File: rtl/nios_mtl_timeout_counter.sv
// nios_mtl_timeout_counter: 16-bit per-transaction cycle budget
module nios_mtl_timeout_counter #(
    parameter int unsigned LIMIT = 255
) (
    input  logic i_clock,
    input  logic i_reset,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_expired
);
    logic [15:0] r_count;
    // clear wins over counting so a new request always starts from zero
    always_ff @(posedge i_clock) begin
        if (i_reset || i_clear) r_count <= '0;
        else if (i_enable) r_count <= r_count + 16'd1;
    end
    assign o_expired = i_enable && (r_count == 16'(LIMIT));
endmodule

// File: rtl/nios_mtl_sysid_checker.sv
// nios_mtl_sysid_checker: reads sysid ID and timestamp over Avalon-MM and compares them
module nios_mtl_sysid_checker
    import nios_mtl_pkg::*;
#(
    parameter logic [31:0] EXPECTED_ID        = 32'd0,
    parameter logic [31:0] EXPECTED_TIMESTAMP = 32'd1459350768,
    parameter int unsigned TIMEOUT_CYCLES     = 255
) (
    input  logic        i_clock,
    input  logic        i_reset,
    input  logic        i_start,
    output logic        o_avm_address,
    output logic        o_avm_read,
    input  logic        i_avm_waitrequest,
    input  logic [31:0] i_avm_readdata,
    input  logic        i_avm_readdatavalid,
    output logic        o_busy,
    output logic        o_done,
    output logic        o_id_ok,
    output logic        o_ts_ok,
    output logic        o_timeout,
    output logic [31:0] o_id_value,
    output logic [31:0] o_ts_value
);
    state_t      r_state;
    logic        r_read, r_addr, r_busy, r_done, r_id_ok, r_ts_ok, r_timeout;
    logic [31:0] r_id_value, r_ts_value;
    logic        w_start_seq, w_id_rsp, w_rsp, w_req, w_clear, w_enable, w_expired;

    assign w_start_seq = (r_state == S_IDLE) && i_start;
    assign w_id_rsp    = (r_state == S_WAIT_ID) && i_avm_readdatavalid;
    assign w_rsp       = w_id_rsp || ((r_state == S_WAIT_TS) && i_avm_readdatavalid);
    assign w_req       = (r_state == S_REQ_ID) || (r_state == S_REQ_TS);
    assign w_clear     = w_start_seq || w_id_rsp;
    assign w_enable    = r_state inside {S_REQ_ID, S_WAIT_ID, S_REQ_TS, S_WAIT_TS};

    nios_mtl_timeout_counter #(.LIMIT(TIMEOUT_CYCLES)) u_timeout (
        .i_clock  (i_clock),
        .i_reset  (i_reset),
        .i_clear  (w_clear),
        .i_enable (w_enable),
        .o_expired(w_expired)
    );

    // sequence FSM with registered bus outputs; a response beats a same-cycle timeout
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_state    <= S_IDLE;
            r_read     <= 1'b0;
            r_addr     <= ADDR_ID;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_id_ok    <= 1'b0;
            r_ts_ok    <= 1'b0;
            r_timeout  <= 1'b0;
            r_id_value <= '0;
            r_ts_value <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: if (i_start) begin
                    r_state    <= S_REQ_ID;
                    r_read     <= 1'b1;
                    r_addr     <= ADDR_ID;
                    r_busy     <= 1'b1;
                    r_id_ok    <= 1'b0;
                    r_ts_ok    <= 1'b0;
                    r_timeout  <= 1'b0;
                    r_id_value <= '0;
                    r_ts_value <= '0;
                end
                S_REQ_ID, S_WAIT_ID, S_REQ_TS, S_WAIT_TS: begin
                    if (w_rsp) begin
                        if (w_id_rsp) begin
                            r_id_value <= i_avm_readdata;
                            r_id_ok    <= (i_avm_readdata == EXPECTED_ID);
                            r_state    <= S_REQ_TS;
                            r_read     <= 1'b1;
                            r_addr     <= ADDR_TIMESTAMP;
                        end else begin
                            r_ts_value <= i_avm_readdata;
                            r_ts_ok    <= (i_avm_readdata == EXPECTED_TIMESTAMP);
                            r_state    <= S_FINISH;
                            r_busy     <= 1'b0;
                            r_done     <= 1'b1;
                        end
                    end else if (w_expired) begin
                        r_state   <= S_FINISH;
                        r_read    <= 1'b0;
                        r_timeout <= 1'b1;
                        r_busy    <= 1'b0;
                        r_done    <= 1'b1;
                    end else if (w_req && !i_avm_waitrequest) begin
                        r_read  <= 1'b0;
                        r_state <= (r_state == S_REQ_ID) ? S_WAIT_ID : S_WAIT_TS;
                    end
                end
                S_FINISH: r_state <= S_IDLE;
                default:  r_state <= S_IDLE;
            endcase
        end
    end

    assign o_avm_address = r_addr;
    assign o_avm_read    = r_read;
    assign o_busy        = r_busy;
    assign o_done        = r_done;
    assign o_id_ok       = r_id_ok;
    assign o_ts_ok       = r_ts_ok;
    assign o_timeout     = r_timeout;
    assign o_id_value    = r_id_value;
    assign o_ts_value    = r_ts_value;
endmodule

// File: tb/tb_nios_mtl_sysid_checker.sv
// tb_nios_mtl_sysid_checker: randomized sysid sequences checked against a per-read outcome model
module tb_nios_mtl_sysid_checker;
    localparam logic [31:0] EXP_ID = 32'd0;
    localparam logic [31:0] EXP_TS = 32'd1459350768;
    localparam int          T      = 4;

    logic        clock = 1'b0, reset = 1'b1, start = 1'b0, wr = 1'b0, rdv = 1'b0;
    logic [31:0] rdata = '0;
    logic        avm_address, avm_read, busy, done, id_ok, ts_ok, timeout;
    logic [31:0] id_value, ts_value;
    int          checks = 0, failures = 0;

    always #5 clock = ~clock;

    nios_mtl_sysid_checker #(
        .EXPECTED_ID(EXP_ID), .EXPECTED_TIMESTAMP(EXP_TS), .TIMEOUT_CYCLES(T)
    ) dut (
        .i_clock(clock), .i_reset(reset), .i_start(start),
        .o_avm_address(avm_address), .o_avm_read(avm_read),
        .i_avm_waitrequest(wr), .i_avm_readdata(rdata), .i_avm_readdatavalid(rdv),
        .o_busy(busy), .o_done(done), .o_id_ok(id_ok), .o_ts_ok(ts_ok), .o_timeout(timeout),
        .o_id_value(id_value), .o_ts_value(ts_value)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // one read succeeds if accepted before the budget runs out and answered by cycle T
    function automatic bit rd_ok(input int w, input int l);
        return l > 0 && w < T && w + l <= T;
    endfunction

    function automatic int rd_cycles(input int w, input int l);
        return rd_ok(w, l) ? w + 1 + l : T + 1;
    endfunction

    task automatic chk_zero(input string tag);
        chk({tag, "_flags"}, {avm_read, avm_address, busy, done, id_ok, ts_ok, timeout}, 0);
        chk({tag, "_idv"}, id_value, 0);
        chk({tag, "_tsv"}, ts_value, 0);
    endtask

    // w = stall cycles per request, l = response delay after accept (0 = never)
    task automatic run_seq(input int w0, input int l0, input int w1, input int l1,
                           input logic [31:0] d0, input logic [31:0] d1, input bit noise);
        int          w[2] = '{w0, w1};
        int          l[2] = '{l0, l1};
        logic [31:0] d[2] = '{d0, d1};
        bit          ok0 = rd_ok(w0, l0);
        bit          ok1 = ok0 && rd_ok(w1, l1);
        int          blen = rd_cycles(w0, l0) + (ok0 ? rd_cycles(w1, l1) : 0);
        int          stall = -1, since = -1, acc = 0, cyc = 0;
        bit          stalled = 0;
        logic        paddr = 0;
        logic [31:0] exp_idv = ok0 ? d0 : 32'd0;
        @(negedge clock);
        start = 1; wr = 0; rdv = 0;
        while (1) begin
            @(negedge clock);
            cyc++;
            start = noise && ($urandom_range(0, 3) == 0);
            rdv = 0;
            rdata = $urandom;
            if (done || cyc > 40) break;
            chk("busy", busy, 1);
            if (stalled) begin
                chk("stall_read", avm_read, 1);
                chk("stall_addr", avm_address, paddr);
            end
            if (since >= 0) begin
                since++;
                if (since == l[acc]) begin
                    rdv = 1; rdata = d[acc]; since = -1;
                end
            end
            if (avm_read) begin
                if (stall < 0) stall = w[avm_address];
                stalled = stall > 0;
                paddr = avm_address;
                if (stall > 0) begin
                    wr = 1; stall--;
                end else begin
                    wr = 0; since = 0; acc = int'(avm_address);
                end
                if (noise && !rdv && $urandom_range(0, 1) == 1) begin
                    rdv = 1; rdata = $urandom;
                end
            end else begin
                wr = 1'($urandom_range(0, 1)); stall = -1; stalled = 0;
            end
        end
        chk("done_seen", done, 1);
        chk("done_cycle", cyc, blen + 1);
        chk("fin_busy", busy, 0);
        chk("fin_read", avm_read, 0);
        chk("id_ok", id_ok, ok0 && d0 == EXP_ID);
        chk("ts_ok", ts_ok, ok1 && d1 == EXP_TS);
        chk("timeout", timeout, !ok1);
        chk("id_value", id_value, exp_idv);
        chk("ts_value", ts_value, ok1 ? d1 : 32'd0);
        start = 1; rdv = 1; rdata = $urandom; wr = 0;
        @(negedge clock);
        start = 0; rdv = 0;
        chk("post_done", done, 0);
        chk("post_busy", busy, 0);
        chk("post_idv", id_value, exp_idv);
    endtask

    initial begin
        repeat (3) @(negedge clock);
        chk_zero("reset");
        reset = 0;
        run_seq(0, 1, 0, 1, EXP_ID, EXP_TS, 0);
        run_seq(0, 1, 0, 1, EXP_ID, EXP_TS - 32'd1, 0);
        run_seq(3, 1, 3, 1, EXP_ID, EXP_TS, 0);
        run_seq(0, 0, 0, 0, EXP_ID, EXP_TS, 0);
        run_seq(5, 1, 0, 1, EXP_ID, EXP_TS, 0);
        run_seq(1, 3, 0, 4, EXP_ID, EXP_TS, 0);
        run_seq(0, 1, 2, 3, EXP_ID, EXP_TS, 0);
        // repeated start while busy, then reset in WAIT_TS with a stray response after
        @(negedge clock);
        start = 1; wr = 0; rdv = 0;
        @(negedge clock);
        start = 0;
        chk("rst_req_read", avm_read, 1);
        @(negedge clock);
        start = 1; rdv = 1; rdata = EXP_ID;
        @(negedge clock);
        start = 0; rdv = 0;
        chk("rst_req_addr", avm_address, 1);
        @(negedge clock);
        chk("rst_wts_busy", busy, 1);
        chk("rst_wts_idok", id_ok, 1);
        reset = 1; start = 1;
        @(negedge clock);
        reset = 0; start = 0;
        chk_zero("rst_mid");
        rdv = 1; rdata = EXP_TS;
        @(negedge clock);
        rdv = 0;
        chk_zero("rst_stray");
        for (int i = 0; i < 40; i++) begin
            int          rw0 = $urandom_range(0, 5), rl0 = $urandom_range(0, 5);
            int          rw1 = $urandom_range(0, 5), rl1 = $urandom_range(0, 5);
            logic [31:0] rd0 = $urandom_range(0, 1) ? EXP_ID : 32'($urandom);
            logic [31:0] rd1 = $urandom_range(0, 1) ? EXP_TS : 32'($urandom);
            run_seq(rw0, rl0, rw1, rl1, rd0, rd1, 1);
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
